regfile_mp_sb: RTL and testbench

//  Parametrised register file for the CPU datapath: one write port, two independent read ports
//  (A/B operands), optional write-through bypass, optional hardwired-zero R0.
//  Per-register pending scoreboard: decode reserves a destination, writeback clears it.

---
 rtl/regfile_mp_sb_pkg.sv | 17 +
 rtl/regfile_mp_sb_if.sv | 29 ++
 rtl/regfile_en_reg.sv | 20 ++
 rtl/regfile_mp_sb.sv | 79 +++++++
 tb/tb_regfile_mp_sb.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants and the index decoder for the register file and the controller hazard logic.
package regfile_mp_sb_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;
    localparam int MAX_DEPTH = 32;
    localparam int MAX_AW    = 5;
    localparam int REG_ZERO  = 0;

    // Out-of-range indices decode to all zeros, so they select nothing and read as 0.
    function automatic logic [MAX_DEPTH-1:0] onehot(input logic [MAX_AW-1:0] idx,
                                                    input int depth);
        onehot = '0;
        if (int'(idx) < depth) onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Write/reserve/read bus between the decode stage and the register file.
interface regfile_mp_sb_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
);
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    writenum;
    logic             write;
    logic             reserve;
    logic [AW-1:0]    reservenum;
    logic [AW-1:0]    readnum_a;
    logic [AW-1:0]    readnum_b;
    logic [WIDTH-1:0] data_out_a;
    logic [WIDTH-1:0] data_out_b;
    logic             pending_a;
    logic             pending_b;
    logic [DEPTH-1:0] pending_vec;

    modport master (
        output data_in, writenum, write, reserve, reservenum, readnum_a, readnum_b,
        input  data_out_a, data_out_b, pending_a, pending_b, pending_vec
    );

    modport slave (
        input  data_in, writenum, write, reserve, reservenum, readnum_a, readnum_b,
        output data_out_a, data_out_b, pending_a, pending_b, pending_vec
    );
endinterface

// File: rtl/regfile_en_reg.sv
// One register-file entry: load-enable register with asynchronous active-low clear.
module regfile_en_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    // NOTE: storage is reset on purpose; reads during and after reset must return 0, never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_q <= '0;
        else if (i_en) r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/regfile_mp_sb.sv
// Register file with one write port, two read ports, optional write-through bypass and R0,
// plus a per-register pending scoreboard (reserve sets, writeback clears, reserve wins).
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    regfile_mp_sb_if.slave bus
);
    logic [DEPTH-1:0] w_wr_mask;
    logic [DEPTH-1:0] w_wr_sel;
    logic [DEPTH-1:0] w_rs_sel;
    logic [WIDTH-1:0] w_q [DEPTH];
    logic [DEPTH-1:0] r_pending;

    always_comb begin
        w_wr_mask = '1;
        if (ZERO_REG) w_wr_mask[REG_ZERO] = 1'b0;
    end

    assign w_wr_sel = DEPTH'(onehot(MAX_AW'(bus.writenum), DEPTH))   & w_wr_mask & {DEPTH{bus.write}};
    assign w_rs_sel = DEPTH'(onehot(MAX_AW'(bus.reservenum), DEPTH)) & w_wr_mask & {DEPTH{bus.reserve}};

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        regfile_en_reg #(.WIDTH(WIDTH)) u_reg (
            .clk  (clk),
            .rst_n(rst_n),
            .i_en (w_wr_sel[i]),
            .i_d  (bus.data_in),
            .o_q  (w_q[i])
        );
    end

    // Reserve is OR-ed in after the writeback clear, so it wins on a same-index collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= (r_pending & ~w_wr_sel) | w_rs_sel;
    end

    logic [AW-1:0]    w_rd_idx  [2];
    logic [WIDTH-1:0] w_rd_data [2];
    logic             w_rd_pend [2];

    assign w_rd_idx[0] = bus.readnum_a;
    assign w_rd_idx[1] = bus.readnum_b;

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DEPTH-1:0] w_sel;
        logic             w_byp;
        logic [WIDTH-1:0] w_mux;

        assign w_sel = DEPTH'(onehot(MAX_AW'(w_rd_idx[p]), DEPTH)) & w_wr_mask;
        // Bypass is gated by rst_n so nothing leaks through while the file is held in reset.
        assign w_byp = BYPASS && rst_n && (|(w_sel & w_wr_sel));

        // NOTE: blocking accumulation inside always_comb with a '0 default first; no latch.
        always_comb begin
            w_mux = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_sel[i]) w_mux = w_mux | w_q[i];
            end
        end

        assign w_rd_data[p] = w_byp ? bus.data_in : w_mux;
        assign w_rd_pend[p] = (|(w_sel & r_pending)) && !w_byp;
    end

    assign bus.data_out_a  = w_rd_data[0];
    assign bus.data_out_b  = w_rd_data[1];
    assign bus.pending_a   = w_rd_pend[0];
    assign bus.pending_b   = w_rd_pend[1];
    assign bus.pending_vec = r_pending;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench: dut0 is the default build, dut1 has DEPTH=6, BYPASS=0, ZERO_REG=1.
module tb_regfile_mp_sb;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    regfile_mp_sb_if #(.WIDTH(16), .DEPTH(8), .AW(3)) bus0 ();
    regfile_mp_sb_if #(.WIDTH(16), .DEPTH(6), .AW(3)) bus1 ();

    regfile_mp_sb #(.WIDTH(16), .DEPTH(8), .AW(3), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    regfile_mp_sb #(.WIDTH(16), .DEPTH(6), .AW(3), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic idle();
        bus0.write = 1'b0; bus0.reserve = 1'b0; bus0.data_in = '0;
        bus0.writenum = '0; bus0.reservenum = '0; bus0.readnum_a = '0; bus0.readnum_b = '0;
        bus1.write = 1'b0; bus1.reserve = 1'b0; bus1.data_in = '0;
        bus1.writenum = '0; bus1.reservenum = '0; bus1.readnum_a = '0; bus1.readnum_b = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        #1 rst_n = 1'b0;
        bus0.write = 1'b1; bus0.writenum = 3'd3; bus0.data_in = 16'h1111; bus0.readnum_a = 3'd3;
        #1;
        n_cmp++; if (bus0.data_out_a !== 16'h0000) begin n_err++; $display("FAIL rst_init_a_bypass: got %h want %h", bus0.data_out_a, 16'h0000); end
        n_cmp++; if (bus0.pending_vec !== 8'h00) begin n_err++; $display("FAIL rst_init_vec: got %h want %h", bus0.pending_vec, 8'h00); end
        n_cmp++; if (bus1.data_out_b !== 16'h0000) begin n_err++; $display("FAIL rst_init_dut1_b: got %h want %h", bus1.data_out_b, 16'h0000); end
        idle();
        @(negedge clk) rst_n = 1'b1;
        #1;
        bus0.write = 1'b1; bus0.writenum = 3'd3; bus0.data_in = 16'hABCD;
        bus0.reserve = 1'b1; bus0.reservenum = 3'd6;
        tick();
        idle();
        bus0.readnum_a = 3'd3; bus0.readnum_b = 3'd6;
        #1;
        n_cmp++; if (bus0.data_out_a !== 16'hABCD) begin n_err++; $display("FAIL rst_pre_r3: got %h want %h", bus0.data_out_a, 16'hABCD); end
        n_cmp++; if (bus0.pending_vec !== 8'h40) begin n_err++; $display("FAIL rst_pre_vec: got %h want %h", bus0.pending_vec, 8'h40); end
        // Mid-cycle reset pulse: everything must clear without a clock edge.
        bus0.write = 1'b1; bus0.writenum = 3'd3; bus0.data_in = 16'h1111;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus0.data_out_a !== 16'h0000) begin n_err++; $display("FAIL rst_async_a: got %h want %h", bus0.data_out_a, 16'h0000); end
        n_cmp++; if (bus0.pending_vec !== 8'h00) begin n_err++; $display("FAIL rst_async_vec: got %h want %h", bus0.pending_vec, 8'h00); end
        n_cmp++; if (bus0.pending_b !== 1'b0) begin n_err++; $display("FAIL rst_async_pend_b: got %b want %b", bus0.pending_b, 1'b0); end
        idle();
        @(negedge clk) rst_n = 1'b1;
        tick();
        bus0.readnum_a = 3'd3;
        #1;
        n_cmp++; if (bus0.data_out_a !== 16'h0000) begin n_err++; $display("FAIL rst_post_r3: got %h want %h", bus0.data_out_a, 16'h0000); end
    endtask

    task automatic test_write_read();
        idle();
        bus0.write = 1'b1; bus0.writenum = 3'd5; bus0.data_in = 16'h1234;
        tick();
        idle();
        bus0.readnum_a = 3'd5; bus0.readnum_b = 3'd5;
        #1;
        n_cmp++; if (bus0.data_out_a !== 16'h1234) begin n_err++; $display("FAIL wr_r5_a: got %h want %h", bus0.data_out_a, 16'h1234); end
        n_cmp++; if (bus0.data_out_b !== 16'h1234) begin n_err++; $display("FAIL wr_r5_b: got %h want %h", bus0.data_out_b, 16'h1234); end
        bus0.readnum_b = 3'd2;
        #1;
        n_cmp++; if (bus0.data_out_b !== 16'h0000) begin n_err++; $display("FAIL wr_r2_b: got %h want %h", bus0.data_out_b, 16'h0000); end
        bus0.write = 1'b1; bus0.writenum = 3'd7; bus0.data_in = 16'hBEEF;
        tick();
        idle();
        bus0.readnum_a = 3'd7; bus0.readnum_b = 3'd5;
        #1;
        n_cmp++; if (bus0.data_out_a !== 16'hBEEF) begin n_err++; $display("FAIL wr_r7_a: got %h want %h", bus0.data_out_a, 16'hBEEF); end
        n_cmp++; if (bus0.data_out_b !== 16'h1234) begin n_err++; $display("FAIL wr_r5_keep_b: got %h want %h", bus0.data_out_b, 16'h1234); end
    endtask

    task automatic test_bypass();
        idle();
        bus0.write = 1'b1; bus0.writenum = 3'd4; bus0.data_in = 16'h00FF;
        bus0.readnum_a = 3'd4; bus0.readnum_b = 3'd5;
        #1;
        n_cmp++; if (bus0.data_out_a !== 16'h00FF) begin n_err++; $display("FAIL byp_same_cycle_a: got %h want %h", bus0.data_out_a, 16'h00FF); end
        n_cmp++; if (bus0.data_out_b !== 16'h1234) begin n_err++; $display("FAIL byp_other_b: got %h want %h", bus0.data_out_b, 16'h1234); end
        tick();
        bus0.write = 1'b0;
        #1;
        n_cmp++; if (bus0.data_out_a !== 16'h00FF) begin n_err++; $display("FAIL byp_stored_a: got %h want %h", bus0.data_out_a, 16'h00FF); end
        bus1.write = 1'b1; bus1.writenum = 3'd4; bus1.data_in = 16'h0A0A;
        tick();
        bus1.data_in = 16'h5555; bus1.readnum_a = 3'd4;
        #1;
        n_cmp++; if (bus1.data_out_a !== 16'h0A0A) begin n_err++; $display("FAIL nobyp_old_a: got %h want %h", bus1.data_out_a, 16'h0A0A); end
        tick();
        bus1.write = 1'b0;
        #1;
        n_cmp++; if (bus1.data_out_a !== 16'h5555) begin n_err++; $display("FAIL nobyp_new_a: got %h want %h", bus1.data_out_a, 16'h5555); end
    endtask

    task automatic test_scoreboard();
        idle();
        bus0.readnum_a = 3'd6; bus0.reserve = 1'b1; bus0.reservenum = 3'd6;
        #1;
        n_cmp++; if (bus0.pending_a !== 1'b0) begin n_err++; $display("FAIL sb_pre_edge: got %b want %b", bus0.pending_a, 1'b0); end
        tick();
        bus0.reserve = 1'b0;
        #1;
        n_cmp++; if (bus0.pending_a !== 1'b1) begin n_err++; $display("FAIL sb_rsv_pend_a: got %b want %b", bus0.pending_a, 1'b1); end
        n_cmp++; if (bus0.pending_vec !== 8'h40) begin n_err++; $display("FAIL sb_rsv_vec: got %h want %h", bus0.pending_vec, 8'h40); end
        bus0.write = 1'b1; bus0.writenum = 3'd6; bus0.data_in = 16'h6666;
        #1;
        n_cmp++; if (bus0.pending_a !== 1'b0) begin n_err++; $display("FAIL sb_wb_byp_pend_a: got %b want %b", bus0.pending_a, 1'b0); end
        n_cmp++; if (bus0.pending_vec !== 8'h40) begin n_err++; $display("FAIL sb_wb_vec_pre: got %h want %h", bus0.pending_vec, 8'h40); end
        tick();
        bus0.write = 1'b0;
        #1;
        n_cmp++; if (bus0.pending_vec !== 8'h00) begin n_err++; $display("FAIL sb_wb_vec_post: got %h want %h", bus0.pending_vec, 8'h00); end
        n_cmp++; if (bus0.data_out_a !== 16'h6666) begin n_err++; $display("FAIL sb_wb_data: got %h want %h", bus0.data_out_a, 16'h6666); end
        bus0.write = 1'b1; bus0.writenum = 3'd6; bus0.data_in = 16'h7777;
        bus0.reserve = 1'b1; bus0.reservenum = 3'd6;
        tick();
        bus0.write = 1'b0; bus0.reserve = 1'b0;
        #1;
        n_cmp++; if (bus0.pending_vec !== 8'h40) begin n_err++; $display("FAIL sb_same_idx_vec: got %h want %h", bus0.pending_vec, 8'h40); end
        n_cmp++; if (bus0.data_out_a !== 16'h7777) begin n_err++; $display("FAIL sb_same_idx_data: got %h want %h", bus0.data_out_a, 16'h7777); end
        bus0.write = 1'b1; bus0.writenum = 3'd6; bus0.data_in = 16'h8888;
        bus0.reserve = 1'b1; bus0.reservenum = 3'd1; bus0.readnum_b = 3'd1;
        tick();
        bus0.write = 1'b0; bus0.reserve = 1'b0;
        #1;
        n_cmp++; if (bus0.pending_vec !== 8'h02) begin n_err++; $display("FAIL sb_diff_idx_vec: got %h want %h", bus0.pending_vec, 8'h02); end
        n_cmp++; if (bus0.pending_b !== 1'b1) begin n_err++; $display("FAIL sb_diff_idx_pend_b: got %b want %b", bus0.pending_b, 1'b1); end
        n_cmp++; if (bus0.data_out_a !== 16'h8888) begin n_err++; $display("FAIL sb_diff_idx_data: got %h want %h", bus0.data_out_a, 16'h8888); end
        bus0.write = 1'b1; bus0.writenum = 3'd2; bus0.data_in = 16'h0002;
        tick();
        bus0.write = 1'b0;
        #1;
        n_cmp++; if (bus0.pending_vec !== 8'h02) begin n_err++; $display("FAIL sb_unreserved_wr_vec: got %h want %h", bus0.pending_vec, 8'h02); end
        bus1.reserve = 1'b1; bus1.reservenum = 3'd2;
        tick();
        bus1.reserve = 1'b0; bus1.readnum_a = 3'd2;
        bus1.write = 1'b1; bus1.writenum = 3'd2; bus1.data_in = 16'h2222;
        #1;
        n_cmp++; if (bus1.pending_a !== 1'b1) begin n_err++; $display("FAIL sb_nobyp_pend_a: got %b want %b", bus1.pending_a, 1'b1); end
        tick();
        bus1.write = 1'b0;
        #1;
        n_cmp++; if (bus1.pending_vec !== 6'h00) begin n_err++; $display("FAIL sb_nobyp_vec_post: got %h want %h", bus1.pending_vec, 6'h00); end
        n_cmp++; if (bus1.data_out_a !== 16'h2222) begin n_err++; $display("FAIL sb_nobyp_data: got %h want %h", bus1.data_out_a, 16'h2222); end
    endtask

    task automatic test_zero_reg();
        idle();
        bus1.write = 1'b1; bus1.writenum = 3'd0; bus1.data_in = 16'hFFFF;
        bus1.reserve = 1'b1; bus1.reservenum = 3'd0;
        bus0.write = 1'b1; bus0.writenum = 3'd0; bus0.data_in = 16'hFFFF;
        tick();
        idle();
        #1;
        n_cmp++; if (bus1.data_out_a !== 16'h0000) begin n_err++; $display("FAIL zr_r0_data: got %h want %h", bus1.data_out_a, 16'h0000); end
        n_cmp++; if (bus1.pending_a !== 1'b0) begin n_err++; $display("FAIL zr_r0_pend_a: got %b want %b", bus1.pending_a, 1'b0); end
        n_cmp++; if (bus1.pending_vec !== 6'h00) begin n_err++; $display("FAIL zr_vec: got %h want %h", bus1.pending_vec, 6'h00); end
        n_cmp++; if (bus0.data_out_a !== 16'hFFFF) begin n_err++; $display("FAIL zr_off_r0_data: got %h want %h", bus0.data_out_a, 16'hFFFF); end
    endtask

    task automatic test_out_of_range();
        logic [15:0] exp1 [6];
        exp1 = '{16'h0000, 16'h0000, 16'h2222, 16'h0000, 16'h5555, 16'h0000};
        idle();
        bus1.write = 1'b1; bus1.writenum = 3'd7; bus1.data_in = 16'hDEAD;
        bus1.reserve = 1'b1; bus1.reservenum = 3'd7;
        tick();
        bus1.writenum = 3'd6; bus1.reservenum = 3'd6; bus1.data_in = 16'hBEEF;
        tick();
        idle();
        bus1.readnum_b = 3'd7;
        #1;
        n_cmp++; if (bus1.pending_vec !== 6'h00) begin n_err++; $display("FAIL oor_vec: got %h want %h", bus1.pending_vec, 6'h00); end
        n_cmp++; if (bus1.data_out_b !== 16'h0000) begin n_err++; $display("FAIL oor_r7_data_b: got %h want %h", bus1.data_out_b, 16'h0000); end
        n_cmp++; if (bus1.pending_b !== 1'b0) begin n_err++; $display("FAIL oor_r7_pend_b: got %b want %b", bus1.pending_b, 1'b0); end
        bus1.readnum_b = 3'd6;
        #1;
        n_cmp++; if (bus1.data_out_b !== 16'h0000) begin n_err++; $display("FAIL oor_r6_data_b: got %h want %h", bus1.data_out_b, 16'h0000); end
        for (int i = 0; i < 6; i++) begin
            bus1.readnum_a = 3'(i);
            #1;
            n_cmp++; if (bus1.data_out_a !== exp1[i]) begin n_err++; $display("FAIL oor_keep_r%0d: got %h want %h", i, bus1.data_out_a, exp1[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_zero_reg();
        test_out_of_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
